// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - 2-stage pipelined add/sub/and/xor ALU with valid/ready handshake and CC register
// Optional ALU_SAT_EN: add/sub results saturate on signed overflow.
module alu_pipe #(
  parameter int unsigned WIDTH    = 64,
  parameter logic [2:0]  CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic             s1_valid;
  logic [1:0]       s1_control;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_set_cc;
  logic             s2_valid;
  logic             s2_set_cc;
  logic             s2_adv;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res;
  logic             c_res;
  logic             ov_res;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  // Subtraction shares the adder as A + ~B + 1; borrow is the inverted carry-out.
  always_comb begin
    is_sub = (s1_control == OP_SUB);
    b_eff  = is_sub ? ~s1_b : s1_b;
    wide   = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    sum    = wide[WIDTH-1:0];
    res    = sum;
    c_res  = 1'b0;
    ov_res = 1'b0;
    case (s1_control)
      OP_ADD: begin
        c_res  = wide[WIDTH];
        ov_res = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        c_res  = !wide[WIDTH];
        ov_res = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND:  res = s1_a & s1_b;
      default: res = s1_a ^ s1_b;
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction follows the sign of A: positive A can only overflow upward.
    if (ov_res)
      res = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_control <= 2'b00;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_set_cc  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_control <= control;
        s1_a       <= a;
        s1_b       <= b;
        s1_set_cc  <= set_cc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_set_cc <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out       <= res;
        carry     <= c_res;
        overflow  <= ov_res;
        s2_set_cc <= s1_set_cc;
      end
    end
  end

  // Flags commit only when the consumer actually takes the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      {cc_zf, cc_sf, cc_of} <= CC_RESET;
    end else if (s2_valid && out_ready && s2_set_cc) begin
      cc_zf <= (out == '0);
      cc_sf <= out[WIDTH-1];
      cc_of <= overflow;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard testbench for alu_pipe (WIDTH=64)
// Honours ALU_SAT_EN in its reference model when the macro is defined.
module tb_alu_pipe;

  localparam int W = 64;
  localparam logic [2:0] CC_RST = 3'b100;
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] out;
    logic         cy;
    logic         ov;
    logic         sc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic [1:0] control;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic set_cc;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out;
  logic carry;
  logic overflow;
  logic cc_zf;
  logic cc_sf;
  logic cc_of;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [2:0] cc_model = CC_RST;
  logic hold_pend = 1'b0;
  logic [W-1:0] hold_out;
  logic hold_cy;
  logic hold_ov;
  logic rand_done;

  alu_pipe #(.WIDTH(W), .CC_RESET(CC_RST)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .a(a), .b(b), .set_cc(set_cc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry(carry), .overflow(overflow),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: signed result computed in W+1 bits, overflow = outside the W-bit signed range.
  function automatic exp_t model(input logic [1:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sc);
    exp_t e;
    logic signed [W:0] sx;
    logic signed [W:0] sy;
    logic signed [W:0] ss;
    logic [W:0] us;
    sx = {x[W-1], x};
    sy = {y[W-1], y};
    e.sc = sc;
    e.cy = 1'b0;
    e.ov = 1'b0;
    case (c)
      2'd0: begin
        ss = sx + sy;
        us = {1'b0, x} + {1'b0, y};
        e.cy = (us >= (65'd1 << W));
        e.out = x + y;
        e.ov = (ss > $signed({1'b0, MAXP})) || (ss < $signed({1'b1, MINN}));
      end
      2'd1: begin
        ss = sx - sy;
        e.cy = (x < y);
        e.out = x - y;
        e.ov = (ss > $signed({1'b0, MAXP})) || (ss < $signed({1'b1, MINN}));
      end
      2'd2: e.out = x & y;
      default: e.out = x ^ y;
    endcase
`ifdef ALU_SAT_EN
    if (e.ov) e.out = (ss > 0) ? MAXP : MINN;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor/scoreboard, sampling 2 time units after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      checks++;
      if ({cc_zf, cc_sf, cc_of} !== cc_model) begin
        errors++;
        $display("FAIL cc actual=%b required=%b", {cc_zf, cc_sf, cc_of}, cc_model);
      end
      if (reset) begin
        q.delete();
        cc_model = CC_RST;
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          checks++;
          if (!out_valid || out !== hold_out || carry !== hold_cy || overflow !== hold_ov) begin
            errors++;
            $display("FAIL hold actual=%b/%h/%b%b required=1/%h/%b%b",
                     out_valid, out, carry, overflow, hold_out, hold_cy, hold_ov);
          end
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", out);
          end else if (out_ready) begin
            e = q.pop_front();
            checks++;
            if (out !== e.out || carry !== e.cy || overflow !== e.ov) begin
              errors++;
              $display("FAIL result actual=%h c=%b o=%b required=%h c=%b o=%b",
                       out, carry, overflow, e.out, e.cy, e.ov);
            end
            if (e.sc) cc_model = {(e.out == '0), e.out[W-1], e.ov};
          end
        end
        hold_pend = out_valid && !out_ready;
        hold_out = out;
        hold_cy = carry;
        hold_ov = overflow;
        if (in_valid && in_ready) q.push_back(model(control, a, b, set_cc));
      end
    end
  end

  // Call at a falling edge; returns at the falling edge after the beat transfers.
  task automatic issue(input logic [1:0] c, input logic [W-1:0] x, input logic [W-1:0] y, input logic sc);
    int budget = 0;
    in_valid = 1'b1;
    control = c;
    a = x;
    b = y;
    set_cc = sc;
    #1;
    while (!in_ready && budget < 60) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL issue_timeout actual=in_ready_low required=in_ready_high");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while ((q.size() != 0 || out_valid) && budget < 200) begin
      @(negedge clk);
      #3;
      budget++;
    end
    checks++;
    if (q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = MAXP;
      3: v = MINN;
      4: v = W'($urandom_range(0, 15));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    control = 2'b00;
    a = '0;
    b = '0;
    set_cc = 1'b0;
    rand_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #3;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_cc", W'({cc_zf, cc_sf, cc_of}), W'(3'b100));
    chk("rst_out", out, '0);
    chk("rst_flags", W'({carry, overflow}), W'(0));
    @(negedge clk);

    // Latency: first beat must be valid two edges after transfer.
    in_valid = 1'b1; control = 2'd0; a = 64'd5; b = 64'd7; set_cc = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    chk("lat_1cyc_not_valid", W'(out_valid), W'(0));
    @(negedge clk);
    #3;
    chk("lat_2cyc_valid", W'(out_valid), W'(1));
    @(negedge clk);

    issue(2'd1, 64'd3, 64'd3, 1'b1);
    issue(2'd1, 64'd0, 64'd1, 1'b1);
    issue(2'd0, MAXP, 64'd1, 1'b1);
    drain();
    issue(2'd2, 64'hF0F0, 64'hFF00, 1'b0);
    drain();

    // Backpressure: four beats with the consumer stalled for five cycles.
    out_ready = 1'b0;
    fork
      begin
        issue(2'd2, 64'h00FF, 64'h0F0F, 1'b1);
        issue(2'd3, 64'h1234, 64'h1234, 1'b1);
        issue(2'd2, '1, MINN, 1'b0);
        issue(2'd3, 64'hAAAA, 64'h5555, 1'b1);
      end
      begin
        repeat (2) @(negedge clk);
        #3;
        chk("bp_in_ready_low", W'(in_ready), W'(0));
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          #3;
          chk("bp_no_gap", W'(out_valid), W'(1));
          @(negedge clk);
        end
      end
    join
    drain();

    // Randomised traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++)
          issue(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    issue(2'd0, 64'd1, 64'd2, 1'b1);
    issue(2'd1, 64'd0, 64'd9, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #3;
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    chk("mid_rst_in_ready", W'(in_ready), W'(1));
    chk("mid_rst_cc", W'({cc_zf, cc_sf, cc_of}), W'(3'b100));
    @(negedge clk);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    chk("no_stale", W'(out_valid), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
